// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the Conv2d datapath: pixel width, output buffer
// geometry, IMAGE_SIZE / CHANNEL_SIZE encodings, output transmitter states
// and a helper to turn a frame edge length into its last row/col index.
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 128;
  localparam int ADDR_W     = 7;

  // Frame edge encodings used by the control unit
  typedef enum logic [2:0] {
    IMG_4   = 3'd0,
    IMG_8   = 3'd1,
    IMG_16  = 3'd2,
    IMG_32  = 3'd3,
    IMG_64  = 3'd4,
    IMG_128 = 3'd5
  } img_size_e;

  // Channel count encodings used by the control unit
  typedef enum logic [2:0] {
    CH_1  = 3'd0,
    CH_2  = 3'd1,
    CH_4  = 3'd2,
    CH_8  = 3'd3,
    CH_16 = 3'd4,
    CH_32 = 3'd5
  } channel_size_e;

  // Output transmitter states
  typedef enum logic [1:0] {
    S_Idle = 2'd0,
    S_Run  = 2'd1,
    S_Done = 2'd2
  } tx_state_e;

  // Decode an IMAGE_SIZE encoding into a pixel count
  function automatic logic [7:0] img_size_decode(input img_size_e enc);
    logic [7:0] size;
    case (enc)
      IMG_4:   size = 8'd4;
      IMG_8:   size = 8'd8;
      IMG_16:  size = 8'd16;
      IMG_32:  size = 8'd32;
      IMG_64:  size = 8'd64;
      IMG_128: size = 8'd128;
      default: size = 8'd4;
    endcase
    return size;
  endfunction

  // Last row/col index of a frame; 128 maps to 127 so it fits 7-bit counters
  function automatic logic [6:0] last_index(input logic [7:0] size);
    logic [7:0] idx;
    idx = size - 8'd1;
    return idx[6:0];
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// -----------------------------------------------------------------------------
// conv_out_fifo
// Synchronous first-word-fall-through FIFO holding output pixels. The head
// entry is always visible on dout while the FIFO is non-empty, so a pixel
// written at edge N can be read in the following cycle.
// Ports:
//   clk    in   clock
//   flush  in   synchronous clear: empties the FIFO (stored data is dropped)
//   push   in   write din this cycle (ignored when full)
//   pop    in   drop the head entry this cycle (ignored when empty)
//   din    in   write data
//   dout   out  head entry
//   count  out  number of stored entries, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module conv_out_fifo
  import conv_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; left without reset so it maps onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/conv_output_axis_tx.sv
// -----------------------------------------------------------------------------
// conv_output_axis_tx
// AXI-Stream master at the output end of the Conv2d datapath. Finished pixels
// from the PE output stage are buffered in an FWFT FIFO and streamed out in
// raster order, with tlast on the final pixel of the frame. Row and frame
// completion pulses and an idle flag go back to the conv control unit.
// Ports:
//   clk                 in   clock, all logic on posedge
//   Reset               in   synchronous active-high reset
//   Start_tx            in   1-cycle pulse: arm a frame and latch IMAGE_SIZE
//   IMAGE_SIZE          in   frame edge in pixels (4..128)
//   in_valid/in_data    in   PE output pixel push port
//   in_ready            out  buffer accepts a pixel this cycle
//   m_axis_tdata        out  stream data (0 while no beat is offered)
//   m_axis_tvalid       out  stream valid
//   m_axis_tready       in   downstream ready
//   m_axis_tlast        out  last pixel of the frame
//   tx_row_done         out  pulse in the cycle after a row's last beat
//   tx_done             out  pulse in the cycle after the tlast beat
//   Output_buffer_IDLE  out  idle with an empty buffer
// -----------------------------------------------------------------------------
module conv_output_axis_tx #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = conv_pkg::FIFO_DEPTH,
  parameter int ADDR_W     = conv_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start_tx,
  input  logic [7:0]            IMAGE_SIZE,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  tx_row_done,
  output logic                  tx_done,
  output logic                  Output_buffer_IDLE
);

  import conv_pkg::*;

  tx_state_e             state_q, state_d;
  logic [7:0]            img_size_q, img_size_d;
  logic [6:0]            row_q, row_d;
  logic [6:0]            col_q, col_d;
  logic                  row_done_q, row_done_d;

  logic [DATA_WIDTH-1:0] fifo_dout_s;
  logic [ADDR_W:0]       fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  fifo_flush_s;

  logic [6:0]            last_idx_s;
  logic                  in_ready_s;
  logic                  tvalid_s;
  logic                  beat_s;
  logic                  push_s;
  logic                  last_col_s;
  logic                  last_row_s;

  assign last_idx_s = last_index(img_size_q);
  assign last_col_s = (col_q == last_idx_s);
  assign last_row_s = (row_q == last_idx_s);

  // No full pass-through: a pop in the same cycle does not open a full buffer
  assign in_ready_s = (state_q == S_Run) && !fifo_full_s;
  assign tvalid_s   = (state_q == S_Run) && !fifo_empty_s;
  assign push_s     = in_valid && in_ready_s;
  assign beat_s     = tvalid_s && m_axis_tready;

  // Anything still buffered once the frame has ended (or on reset) is dropped,
  // so the block always returns to an empty, idle buffer
  assign fifo_flush_s = Reset || (state_q == S_Done);

  conv_out_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .flush (fifo_flush_s),
    .push  (push_s),
    .pop   (beat_s),
    .din   (in_data),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, frame-size latch and raster counters
  always_comb begin
    state_d    = state_q;
    img_size_d = img_size_q;
    row_d      = row_q;
    col_d      = col_q;
    row_done_d = 1'b0;
    case (state_q)
      S_Idle: begin
        if (Start_tx) begin
          img_size_d = IMAGE_SIZE;
          row_d      = 7'd0;
          col_d      = 7'd0;
          state_d    = S_Run;
        end else begin
          state_d = S_Idle;
        end
      end
      S_Run: begin
        // Start_tx is deliberately not looked at here
        if (beat_s) begin
          row_done_d = last_col_s;
          if (last_col_s) begin
            col_d = 7'd0;
            if (last_row_s) begin
              row_d   = 7'd0;
              state_d = S_Done;
            end else begin
              row_d = row_q + 7'd1;
            end
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          state_d = S_Run;
        end
      end
      S_Done: begin
        state_d = S_Idle;
      end
      default: begin
        state_d = S_Idle;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_Idle;
      img_size_q <= 8'd0;
      row_q      <= 7'd0;
      col_q      <= 7'd0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_size_q <= img_size_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_done_q <= row_done_d;
    end
  end

  assign in_ready           = in_ready_s;
  assign m_axis_tvalid      = tvalid_s;
  assign m_axis_tdata       = tvalid_s ? fifo_dout_s : '0;
  assign m_axis_tlast       = tvalid_s && last_col_s && last_row_s;
  assign tx_row_done        = row_done_q;
  assign tx_done            = (state_q == S_Done);
  assign Output_buffer_IDLE = (state_q == S_Idle) && (fifo_count_s == '0);

endmodule

// File: tb/tb_conv_output_axis_tx.sv
module tb_conv_output_axis_tx;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start_tx;
  logic [7:0]  IMAGE_SIZE;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        tx_row_done;
  logic        tx_done;
  logic        Output_buffer_IDLE;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_output_axis_tx dut (
    .clk                (clk),
    .Reset              (Reset),
    .Start_tx           (Start_tx),
    .IMAGE_SIZE         (IMAGE_SIZE),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .tx_row_done        (tx_row_done),
    .tx_done            (tx_done),
    .Output_buffer_IDLE (Output_buffer_IDLE)
  );

  // mode: 0 tready=1, 1 toggle, 2 held low for 'stall' cycles, 3 low every 3rd cycle
  typedef struct {
    int size;
    int mode;
    int stall;
    int gap;
    int mid_start;
    int reset_after;
    int exp_accept;
    int exp_beats;
    int exp_rows;
    int exp_lasts;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_row_done"}, tx_row_done, 0);
    chk({tag, "_tx_done"}, tx_done, 0);
    chk({tag, "_idle"}, Output_buffer_IDLE, 1);
  endtask

  task automatic run_frame(input vec_t v, output int beats_o, output int rows_o, output int lasts_o);
    int n;
    int pushed;
    int beats;
    int rows;
    int lasts;
    int cyc;
    int cnt;
    int budget;
    bit rd_pend;
    bit done_pend;
    bit prev_stall;
    bit finished;
    bit aborted;
    bit push;
    bit beat;
    logic [15:0] prev_data;
    logic prev_last;
    n = v.size * v.size;
    pushed = 0; beats = 0; rows = 0; lasts = 0; cyc = 0;
    budget = n * 4 + 400;
    rd_pend = 0; done_pend = 0; prev_stall = 0; finished = 0; aborted = 0;
    prev_data = 16'd0; prev_last = 1'b0;

    @(negedge clk);
    IMAGE_SIZE = 8'(v.size);
    Start_tx = 1'b1;
    @(negedge clk);
    Start_tx = 1'b0;

    while (!finished && !aborted) begin
      cnt = pushed - beats;
      chk("tx_row_done", tx_row_done, rd_pend);
      if (tx_row_done) rows++;
      chk("tx_done", tx_done, done_pend);
      chk("idle_busy", Output_buffer_IDLE, 0);
      if (done_pend) begin
        chk("tvalid_after_last", m_axis_tvalid, 0);
        chk("in_ready_after_last", in_ready, 0);
        finished = 1;
      end else if (cyc >= budget) begin
        checks++;
        failures++;
        $display("FAIL timeout size=%0d beats=%0d required=%0d", v.size, beats, n);
        aborted = 1;
      end else if (v.reset_after >= 0 && beats == v.reset_after) begin
        Reset = 1'b1;
        in_valid = 1'b0;
        m_axis_tready = 1'b0;
        Start_tx = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        Reset = 1'b0;
        aborted = 1;
      end else begin
        chk("tvalid", m_axis_tvalid, (cnt > 0));
        chk("in_ready", in_ready, (cnt < DEPTH));
        if (prev_stall) begin
          chk("hold_tvalid", m_axis_tvalid, 1);
          chk("hold_tdata", m_axis_tdata, prev_data);
          chk("hold_tlast", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid) begin
          chk("tdata", m_axis_tdata, beats + 1);
          chk("tlast", m_axis_tlast, (beats == n - 1));
        end
        if (v.exp_accept >= 0 && cyc == v.stall) begin
          chk("accepted_while_stalled", pushed, v.exp_accept);
          chk("in_ready_full", in_ready, 0);
        end

        case (v.mode)
          0: m_axis_tready = 1'b1;
          1: m_axis_tready = (cyc % 2 == 0);
          2: m_axis_tready = (cyc >= v.stall);
          3: m_axis_tready = (cyc % 3 != 0);
          default: m_axis_tready = 1'b1;
        endcase
        in_valid = (pushed < n) && !(v.gap != 0 && cyc % 4 == 3);
        in_data = 16'(pushed + 1);
        if (cyc == v.mid_start) begin
          Start_tx = 1'b1;
          IMAGE_SIZE = 8'd4;
        end else begin
          Start_tx = 1'b0;
        end

        push = in_valid && in_ready;
        beat = m_axis_tvalid && m_axis_tready;
        if (push) pushed++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        rd_pend = 0;
        done_pend = 0;
        if (beat) begin
          rd_pend = ((beats + 1) % v.size == 0);
          done_pend = (beats == n - 1);
          if (m_axis_tlast) lasts++;
          beats++;
        end
        cyc++;
        @(negedge clk);
      end
    end

    in_valid = 1'b0;
    Start_tx = 1'b0;
    if (finished) begin
      @(negedge clk);
      chk("idle_after_frame", Output_buffer_IDLE, 1);
      chk("tx_done_single", tx_done, 0);
      chk("row_done_single", tx_row_done, 0);
      chk("tvalid_idle", m_axis_tvalid, 0);
      chk("in_ready_idle", in_ready, 0);
    end
    beats_o = beats;
    rows_o = rows;
    lasts_o = lasts;
  endtask

  initial begin
    int b;
    int r;
    int l;
    Reset = 1'b1;
    Start_tx = 1'b0;
    IMAGE_SIZE = 8'd0;
    in_valid = 1'b0;
    in_data = 16'd0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    Reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_no_start");

    //           size mode stall gap mid reset accept beats rows lasts
    vecs[0] = '{4,   0,   0,    0,  -1, -1,   -1,    16,    4,   1};
    vecs[1] = '{8,   1,   0,    0,  -1, -1,   -1,    64,    8,   1};
    vecs[2] = '{128, 2,   200,  0,  -1, -1,   128,   16384, 128, 1};
    vecs[3] = '{8,   0,   0,    0,  -1, 5,    -1,    5,     0,   0};
    vecs[4] = '{8,   0,   0,    0,  -1, -1,   -1,    64,    8,   1};
    vecs[5] = '{8,   0,   0,    0,  20, -1,   -1,    64,    8,   1};
    vecs[6] = '{16,  3,   0,    1,  -1, -1,   -1,    256,   16,  1};
    vecs[7] = '{32,  0,   0,    0,  -1, -1,   -1,    1024,  32,  1};

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], b, r, l);
      chk($sformatf("vec%0d_beats", i), b, vecs[i].exp_beats);
      chk($sformatf("vec%0d_rows", i), r, vecs[i].exp_rows);
      chk($sformatf("vec%0d_lasts", i), l, vecs[i].exp_lasts);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
